// File: rtl/invaders_pkg.sv
// rtl/invaders_pkg.sv - shared widths, reset wave and direction encodings for invaders
package invaders_pkg;
  localparam int ARRAY_W = 20;
  localparam int ROW_W   = 4;

  typedef enum logic {
    DIR_TO_MSB = 1'b0,
    DIR_TO_LSB = 1'b1
  } dir_e;

  localparam logic [ARRAY_W-1:0] INIT_ARRAY = 20'h001FF;
  localparam logic [ROW_W-1:0]   INIT_ROW   = 4'd1;
  localparam logic [ROW_W-1:0]   LAST_ROW   = 4'd15;
  localparam dir_e               INIT_DIR   = DIR_TO_MSB;
endpackage

// File: rtl/speed_timer.sv
// rtl/speed_timer.sv - counts 0..SPEED_DIV-1 and emits a registered one-cycle tick after each wrap
module speed_timer #(
  parameter logic [31:0] SPEED_DIV = 32'd12_500_000
) (
  input  logic i_clk,
  input  logic i_reset,
  output logic o_q
);
  logic [31:0] r_count;
  logic        r_q;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_count <= 32'd0;
      r_q     <= 1'b0;
    end else if (r_count == SPEED_DIV - 32'd1) begin
      r_count <= 32'd0;
      r_q     <= 1'b1;
    end else begin
      r_count <= r_count + 32'd1;
      r_q     <= 1'b0;
    end
  end

  assign o_q = r_q;
endmodule

// File: rtl/invaders.sv
// rtl/invaders.sv - marching invader line with bullet hit detection
// Optional INVADERS_RESPAWN_EN: reload the wave when cleared or at end of descent.
module invaders
  import invaders_pkg::*;
#(
  parameter logic [31:0] SPEED_DIV = 32'd12_500_000
) (
  input  logic               i_clk_25MHz,
  input  logic               i_reset,
  input  logic [4:0]         i_bullet_x,
  input  logic [ROW_W-1:0]   i_bullet_y,
  output logic [ARRAY_W-1:0] o_invaders_array,
  output logic [ROW_W-1:0]   o_invaders_row,
  output logic               o_hit
);
  logic               w_tick;
  logic [ARRAY_W-1:0] w_mask;
  logic               w_hit;
  logic [ARRAY_W-1:0] w_cleared;
  logic [ARRAY_W-1:0] w_moved;
  logic               w_turn;
  logic               w_eod;

  logic [ARRAY_W-1:0] r_array;
  logic [ROW_W-1:0]   r_row;
  dir_e               r_dir;
  logic               r_hit;
`ifndef INVADERS_RESPAWN_EN
  logic               r_frozen;
`endif

  speed_timer #(.SPEED_DIV(SPEED_DIV)) speed_timer1 (
    .i_clk   (i_clk_25MHz),
    .i_reset (i_reset),
    .o_q     (w_tick)
  );

  // Hit is judged on the pre-move array; the move then operates on the cleared copy.
  always_comb begin
    w_mask    = ARRAY_W'(1) << i_bullet_x;
    w_hit     = (i_bullet_y == r_row) && (i_bullet_x < 5'd20) && (|(r_array & w_mask));
    w_cleared = w_hit ? (r_array & ~w_mask) : r_array;
    w_turn    = (r_dir == DIR_TO_MSB) ? w_cleared[ARRAY_W-1] : w_cleared[0];
    w_eod     = w_turn && (r_row == LAST_ROW);
    w_moved   = (r_dir == DIR_TO_MSB) ? (w_cleared << 1) : (w_cleared >> 1);
  end

  always_ff @(posedge i_clk_25MHz or negedge i_reset) begin
    if (!i_reset) begin
      r_array  <= INIT_ARRAY;
      r_row    <= INIT_ROW;
      r_dir    <= INIT_DIR;
      r_hit    <= 1'b0;
`ifndef INVADERS_RESPAWN_EN
      r_frozen <= 1'b0;
`endif
    end else begin
      r_hit   <= w_hit;
      r_array <= w_cleared;
      if (w_tick) begin
`ifdef INVADERS_RESPAWN_EN
        if ((w_cleared == '0) || w_eod) begin
          r_array <= INIT_ARRAY;
          r_row   <= INIT_ROW;
          r_dir   <= INIT_DIR;
        end else if (w_turn) begin
          r_dir <= (r_dir == DIR_TO_MSB) ? DIR_TO_LSB : DIR_TO_MSB;
          r_row <= r_row + 4'd1;
        end else begin
          r_array <= w_moved;
        end
`else
        if (!r_frozen) begin
          if (w_eod) begin
            r_frozen <= 1'b1;
          end else if (w_turn) begin
            r_dir <= (r_dir == DIR_TO_MSB) ? DIR_TO_LSB : DIR_TO_MSB;
            r_row <= r_row + 4'd1;
          end else begin
            r_array <= w_moved;
          end
        end
`endif
      end
    end
  end

  assign o_invaders_array = r_array;
  assign o_invaders_row   = r_row;
  assign o_hit            = r_hit;
endmodule

// File: tb/tb_invaders.sv
// tb/tb_invaders.sv - scoreboard bench for invaders with SPEED_DIV=4
module tb_invaders;
  logic        clk;
  logic        rst_n;
  logic [4:0]  bx;
  logic [3:0]  by;
  logic [19:0] arr;
  logic [3:0]  row;
  logic        hit;

  invaders #(.SPEED_DIV(32'd4)) dut (
    .i_clk_25MHz      (clk),
    .i_reset          (rst_n),
    .i_bullet_x       (bx),
    .i_bullet_y       (by),
    .o_invaders_array (arr),
    .o_invaders_row   (row),
    .o_hit            (hit)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Edge index since reset release: after edge k, cyc == k.
  int cyc;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  typedef struct {
    int          cyc;
    logic [19:0] arr;
    logic [3:0]  row;
    logic        hit;
    string       name;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int checks = 0;
  int errors = 0;

  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      e = q.pop_front();
      checks++;
      if (e.cyc != cyc || arr !== e.arr || row !== e.row || hit !== e.hit) begin
        errors++;
        $display("FAIL %s cyc=%0d: got array=%h row=%0d hit=%b, want cyc=%0d array=%h row=%0d hit=%b",
                 e.name, cyc, arr, row, hit, e.cyc, e.arr, e.row, e.hit);
      end
    end
  end

  task automatic expect_at(input int c, input logic [19:0] a, input logic [3:0] r,
                           input logic h, input string n);
    exp_t x;
    x.cyc = c; x.arr = a; x.row = r; x.hit = h; x.name = n;
    q.push_back(x);
  endtask

  task automatic do_reset();
    bx = 5'd31; by = 4'd0;
    rst_n = 1'b0;
    @(negedge clk);
    expect_at(0, 20'h001FF, 4'd1, 1'b0, "reset");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic step(input logic [4:0] x, input logic [3:0] y);
    bx = x; by = y;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    bx = 5'd31; by = 4'd0;

    // march and edge turn
    do_reset();
    expect_at(4,  20'h001FF, 4'd1, 1'b0, "pre_first_move");
    expect_at(5,  20'h003FE, 4'd1, 1'b0, "first_move");
    expect_at(45, 20'hFF800, 4'd1, 1'b0, "eleven_ticks");
    expect_at(48, 20'hFF800, 4'd1, 1'b0, "hold_before_turn");
    expect_at(49, 20'hFF800, 4'd2, 1'b0, "turn_row2");
    expect_at(53, 20'h7FC00, 4'd2, 1'b0, "move_after_turn");
    for (int i = 0; i < 54; i++) step(5'd31, 4'd0);

    // hits, row mismatch, out-of-range column
    do_reset();
    expect_at(1, 20'h001F7, 4'd1, 1'b1, "hit_x3");
    expect_at(2, 20'h001F7, 4'd1, 1'b0, "hit_single_pulse");
    expect_at(3, 20'h001F7, 4'd1, 1'b0, "wrong_row");
    expect_at(4, 20'h001F7, 4'd1, 1'b0, "x_out_of_range");
    expect_at(5, 20'h003EE, 4'd1, 1'b0, "move_after_hit");
    step(5'd3,  4'd1);
    step(5'd3,  4'd2);
    step(5'd4,  4'd2);
    step(5'd25, 4'd1);
    step(5'd31, 4'd0);
    step(5'd31, 4'd0);

    // hit and tick on the same edge
    do_reset();
    expect_at(4, 20'h001FF, 4'd1, 1'b0, "pre_simul");
    expect_at(5, 20'h003FC, 4'd1, 1'b1, "simul_hit_tick");
    expect_at(6, 20'h003FC, 4'd1, 1'b0, "post_simul");
    for (int i = 0; i < 4; i++) step(5'd31, 4'd0);
    step(5'd0, 4'd1);
    step(5'd31, 4'd0);
    step(5'd31, 4'd0);

    // clear the whole wave, then see what the next ticks do
    do_reset();
    expect_at(5,  20'h003C0, 4'd1, 1'b1, "clear_mid_tick");
    expect_at(10, 20'h00000, 4'd1, 1'b1, "wave_cleared");
    expect_at(12, 20'h00000, 4'd1, 1'b0, "empty_no_hit");
`ifdef INVADERS_RESPAWN_EN
    expect_at(13, 20'h001FF, 4'd1, 1'b0, "respawn");
    expect_at(17, 20'h003FE, 4'd1, 1'b0, "respawn_moves");
`else
    expect_at(13, 20'h00000, 4'd1, 1'b0, "stay_empty");
    expect_at(17, 20'h00000, 4'd1, 1'b0, "stay_empty_late");
`endif
    for (int i = 0; i < 5; i++) step(5'(i), 4'd1);
    step(5'd6, 4'd1);
    step(5'd7, 4'd1);
    step(5'd8, 4'd1);
    step(5'd31, 4'd0);
    step(5'd10, 4'd1);
    step(5'd12, 4'd1);
    for (int i = 0; i < 7; i++) step(5'd31, 4'd0);

    @(negedge clk);
    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, want 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/invaders.md
INVADERS -- requirements
Module: invaders

Interface
REQ-001 SHALL have parameter SPEED_DIV, default 12_500_000, meaning clock cycles per invader move step (2 Hz at 25 MHz); legal range 2..2^32-1.
REQ-002 SHALL have port i_clk_25MHz, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port i_reset, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port i_bullet_x, input, 5 bits: bullet column, 0..19 valid; 20..31 never hit.
REQ-005 SHALL have port i_bullet_y, input, 4 bits: bullet row.
REQ-006 SHALL have port o_invaders_array, output, 20 bits, registered: bit i set means an invader is alive in column i.
REQ-007 SHALL have port o_invaders_row, output, 4 bits, registered: current row of the invader line.
REQ-008 SHALL have port o_hit, output, 1 bit, registered: one-cycle pulse on a bullet hit.

Function
REQ-009 SHALL hold internal 1-bit direction: 0 moves toward bit 19, 1 moves toward bit 0.
REQ-010 SHALL derive a move tick from a 32-bit counter counting 0..SPEED_DIV-1 and wrapping; the tick is registered high for exactly one cycle after the counter wraps, so the first move occurs on rising edge SPEED_DIV+1 after reset release.
REQ-011 SHALL on a tick with direction=0: if bit 19 is set, set direction to 1, increment the row, and leave the array unchanged; otherwise shift the array left by 1.
REQ-012 SHALL on a tick with direction=1: if bit 0 is set, set direction to 0, increment the row, and leave the array unchanged; otherwise shift the array right by 1.
REQ-013 SHALL detect a hit when i_bullet_y equals o_invaders_row, i_bullet_x is below 20, and array[i_bullet_x] is 1; on that edge it SHALL clear that bit and set o_hit to 1; otherwise o_hit is 0.
REQ-014 SHALL on a hit and a tick in the same cycle evaluate the hit on the pre-move array and then apply the move to the cleared array.
REQ-015 SHALL on a tick that would increment the row from 15 apply the end-of-descent rule (REQ-019/020) instead of wrapping.
REQ-016 SHALL raise no hit when the array is empty.

Reset
REQ-017 SHALL while i_reset=0 asynchronously force: array=20'h001FF, row=1, direction=0, o_hit=0, counter=0, tick=0.
REQ-018 SHALL start counting and moving on the first rising edge after i_reset returns to 1; a reset mid-move discards all progress.

Configuration
REQ-019 SHALL with macro INVADERS_RESPAWN_EN defined reload the wave on a tick when the array is empty or at end of descent: array=20'h001FF, row=1, direction=0; this reload replaces the move.
REQ-020 SHALL without INVADERS_RESPAWN_EN hold row at 15 and freeze array and direction once end of descent is reached, and leave an empty array empty until reset; hits continue to be detected.

Structure
REQ-021 SHALL take ARRAY_W=20, ROW_W=4, INIT_ARRAY=20'h001FF, INIT_ROW=4'd1, and the direction encodings from shared package invaders_pkg.
REQ-022 SHALL implement the tick generator as sub-module speed_timer (parameter SPEED_DIV, 32-bit count, registered o_q), instantiated as speed_timer1.

Verification (SPEED_DIV=4)
REQ-023 SHALL verify reset: i_reset=0 -> array=0x001FF, row=1, o_hit=0; after release, the first move at edge 5 gives array=0x003FE.
REQ-024 SHALL verify the edge turn: with array=0x001FF, after 11 ticks bit 19 is set (0xFF800); the next tick gives row=2, direction=1, array unchanged; the following tick gives 0x7FC00.
REQ-025 SHALL verify a hit: bullet x=3, y=1 right after reset -> array=0x001F7 and a single o_hit pulse; bullet x=3, y=2 -> no change and o_hit=0.
REQ-026 SHALL verify out-of-range x: bullet x=25, y=1 -> no hit.
REQ-027 SHALL verify a simultaneous hit and tick: bullet x=0, y=1 on the first tick edge -> array=0x003FC.
REQ-028 SHALL verify respawn with INVADERS_RESPAWN_EN: all 9 invaders hit -> on the next tick array=0x001FF, row=1; without the macro the array stays 0.
